conv3x3_scan_accel: RTL and testbench



---
 rtl/conv3x3_scan_accel.sv | 149 ++++++++++++++
 tb/tb_conv3x3_scan_accel.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_scan_accel.sv
// conv3x3_scan_accel: Sobel 3x3 scan over a horizontal patch strip read from SRAM,
// one outstanding read at a time, counting patches whose gradient exceeds a threshold.
module conv3x3_scan_accel #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int PIX_W = 8,
    parameter int STRIDE = 64,
    parameter int MAX_PATCHES = 64,
    localparam int CNT_W = $clog2(MAX_PATCHES + 1),
    localparam int RES_W = PIX_W + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [15:0]      row,
    input  logic [15:0]      col,
    input  logic [CNT_W-1:0] num_patches,
    input  logic [RES_W-1:0] threshold,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic [RES_W-1:0] last_result,
    output logic             sram_req,
    output logic [31:0]      sram_addr,
    input  logic             sram_gnt,
    input  logic [PIX_W-1:0] sram_rdata,
    input  logic             sram_rvalid
);
    typedef enum logic [2:0] {IDLE, FETCH, WAIT, CALC, DONE} state_t;
    state_t state;
    logic [1:0] mode_r;
    logic [15:0] row_r, col_r;
    logic [CNT_W-1:0] n_r, k;
    logic [RES_W-1:0] thr_r;
    logic [CNT_W:0] fcol;
    logic [1:0] frow;
    logic [PIX_W-1:0] w [3][3];
    logic [PIX_W-1:0] nc [3];
    logic signed [RES_W-1:0] gx, gy;
    logic [RES_W-1:0] ax, ay, res;
    logic [RES_W:0] sum;

    function automatic logic [31:0] addr_f(logic [15:0] r0, logic [15:0] c0, logic [1:0] r, logic [CNT_W:0] c);
        return BASE_ADDR + (32'(r0) + 32'(r)) * 32'(STRIDE) + 32'(c0) + 32'(c);
    endfunction

    function automatic logic signed [RES_W-1:0] sx(logic [PIX_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    always_comb begin
        gx = (sx(w[0][2]) + (sx(w[1][2]) <<< 1) + sx(w[2][2])) - (sx(w[0][0]) + (sx(w[1][0]) <<< 1) + sx(w[2][0]));
        gy = (sx(w[2][0]) + (sx(w[2][1]) <<< 1) + sx(w[2][2])) - (sx(w[0][0]) + (sx(w[0][1]) <<< 1) + sx(w[0][2]));
        ax = gx[RES_W-1] ? RES_W'(-gx) : RES_W'(gx);
        ay = gy[RES_W-1] ? RES_W'(-gy) : RES_W'(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        res = mode_r == 2'd0 ? ax : mode_r == 2'd1 ? ay : sum[RES_W] ? '1 : sum[RES_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            sram_req <= 1'b0;
            sram_addr <= '0;
            match_count <= '0;
            last_result <= '0;
            mode_r <= '0;
            row_r <= '0;
            col_r <= '0;
            n_r <= '0;
            thr_r <= '0;
            k <= '0;
            fcol <= '0;
            frow <= '0;
            for (int i = 0; i < 3; i++) begin
                nc[i] <= '0;
                for (int j = 0; j < 3; j++) w[i][j] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    mode_r <= mode;
                    row_r <= row;
                    col_r <= col;
                    n_r <= num_patches;
                    thr_r <= threshold;
                    match_count <= '0;
                    k <= '0;
                    fcol <= '0;
                    frow <= '0;
                    done <= num_patches == '0;
                    busy <= num_patches != '0;
                    sram_req <= num_patches != '0;
                    sram_addr <= addr_f(row, col, '0, '0);
                    state <= num_patches == '0 ? DONE : FETCH;
                end
                FETCH: if (sram_gnt) begin
                    sram_req <= 1'b0;
                    state <= WAIT;
                end
                WAIT: if (sram_rvalid) begin
                    if (frow != 2'd2) begin
                        nc[frow] <= sram_rdata;
                        frow <= frow + 2'd1;
                        sram_req <= 1'b1;
                        sram_addr <= addr_f(row_r, col_r, frow + 2'd1, fcol);
                        state <= FETCH;
                    end else begin
                        // column complete: shift the window left, new column enters on the right
                        for (int i = 0; i < 3; i++) begin
                            w[i][0] <= w[i][1];
                            w[i][1] <= w[i][2];
                        end
                        w[0][2] <= nc[0];
                        w[1][2] <= nc[1];
                        w[2][2] <= sram_rdata;
                        frow <= '0;
                        if (fcol == (CNT_W+1)'(k) + (CNT_W+1)'(2)) begin
                            state <= CALC;
                        end else begin
                            fcol <= fcol + (CNT_W+1)'(1);
                            sram_req <= 1'b1;
                            sram_addr <= addr_f(row_r, col_r, '0, fcol + (CNT_W+1)'(1));
                            state <= FETCH;
                        end
                    end
                end
                CALC: begin
                    last_result <= res;
                    if (res > thr_r) match_count <= match_count + CNT_W'(1);
                    if ((CNT_W+1)'(k) + (CNT_W+1)'(1) < (CNT_W+1)'(n_r)) begin
                        k <= k + CNT_W'(1);
                        fcol <= fcol + (CNT_W+1)'(1);
                        sram_req <= 1'b1;
                        sram_addr <= addr_f(row_r, col_r, '0, fcol + (CNT_W+1)'(1));
                        state <= FETCH;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv3x3_scan_accel.sv
// tb_conv3x3_scan_accel: directed scenarios against a behavioural SRAM holding small synthetic images.
module tb_conv3x3_scan_accel;
    logic clk = 0;
    logic rst, start, busy, done, sram_req, sram_gnt, sram_rvalid;
    logic [1:0] mode;
    logic [15:0] row, col;
    logic [6:0] num_patches, match_count;
    logic [10:0] threshold, last_result;
    logic [31:0] sram_addr;
    logic [7:0] sram_rdata;

    int checks = 0, failures = 0;
    int kind = 0, gnt_wait = 0, rv_extra = 0;
    int rv_cnt = 0, rv_num = 0, gnt_num = 0, waited = 0, addr_err = 0;
    logic [31:0] pend, req_addr, first_addr;
    logic [10:0] results[$];
    logic cap = 0;

    conv3x3_scan_accel dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .row(row), .col(col),
        .num_patches(num_patches), .threshold(threshold), .busy(busy), .done(done),
        .match_count(match_count), .last_result(last_result), .sram_req(sram_req),
        .sram_addr(sram_addr), .sram_gnt(sram_gnt), .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pix_at(logic [31:0] a);
        int off, r, c;
        off = int'(a - 32'h1000_0000);
        r = off / 64;
        c = off % 64;
        case (kind)
            0: return 8'd50;
            1: return c >= 2 ? 8'd200 : 8'd0;
            2: return r >= 1 ? 8'd100 : 8'd0;
            default: return c >= 2 ? 8'd0 : 8'd200;
        endcase
    endfunction

    // SRAM model: grant after gnt_wait stalled cycles, data 1+rv_extra cycles after grant
    initial begin
        sram_gnt = 0; sram_rvalid = 0; sram_rdata = 0;
        forever begin
            @(negedge clk);
            sram_gnt = 0;
            sram_rvalid = 0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    sram_rvalid = 1;
                    sram_rdata = pix_at(pend);
                    rv_num++;
                end
            end
            if (!sram_req && waited > 0) addr_err++;
            if (sram_req) begin
                if (waited == 0) req_addr = sram_addr;
                else if (sram_addr !== req_addr) addr_err++;
                if (gnt_num == 0 && waited == 0) first_addr = sram_addr;
                if (waited >= gnt_wait) begin
                    sram_gnt = 1;
                    pend = sram_addr;
                    rv_cnt = 1 + rv_extra;
                    gnt_num++;
                    waited = 0;
                end else waited++;
            end
        end
    end

    // capture last_result after each CALC (the cycle after a patch's final pixel)
    initial forever begin
        @(posedge clk);
        #1;
        if (cap) begin results.push_back(last_result); cap = 0; end
        if (sram_rvalid && busy && rv_num >= 9 && (rv_num - 9) % 3 == 0) cap = 1;
    end

    task automatic run(input logic [1:0] m, input int r, input int c, input int n, input int thr, input int glitch, output int cyc);
        results.delete();
        rv_num = 0; gnt_num = 0; addr_err = 0;
        @(negedge clk);
        mode = m; row = 16'(r); col = 16'(c); num_patches = 7'(n); threshold = 11'(thr); start = 1;
        cyc = 0;
        while (cyc < 3000) begin
            @(posedge clk);
            #1;
            start = 0;
            cyc++;
            if (glitch != 0 && cyc == glitch) begin
                start = 1; num_patches = 7'd1; mode = 2'd1; threshold = 11'd0;
            end
            if (done) break;
        end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL run_timeout got done=%b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1; start = 0; mode = 0; row = 0; col = 0; num_patches = 0; threshold = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, sram_req} !== 3'b000) begin failures++; $display("FAIL reset_flags got %b want 000", {busy, done, sram_req}); end
        checks++;
        if (sram_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want 0", sram_addr); end
        checks++;
        if ({match_count, last_result} !== 18'h0) begin failures++; $display("FAIL reset_counts got %0d/%0d want 0/0", match_count, last_result); end
        rst = 0;
    endtask

    task automatic test_uniform;
        int cyc;
        kind = 0;
        run(2'd2, 0, 0, 4, 0, 0, cyc);
        checks++;
        if (cyc != 41) begin failures++; $display("FAIL uniform_latency got %0d want 41", cyc); end
        checks++;
        if (gnt_num != 18) begin failures++; $display("FAIL uniform_reads got %0d want 18", gnt_num); end
        checks++;
        if (last_result !== 11'd0 || match_count !== 7'd0) begin failures++; $display("FAIL uniform_result got %0d/%0d want 0/0", last_result, match_count); end
        checks++;
        if (results.size() != 4) begin failures++; $display("FAIL uniform_calcs got %0d want 4", results.size()); end
    endtask

    task automatic test_step_gx;
        int cyc;
        int e[3] = '{800, 800, 0};
        kind = 1;
        run(2'd0, 0, 0, 3, 100, 0, cyc);
        checks++;
        if (cyc != 34) begin failures++; $display("FAIL gx_latency got %0d want 34", cyc); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (results.size() <= i || results[i] !== 11'(e[i])) begin failures++; $display("FAIL gx_result%0d got %0d want %0d", i, results.size() > i ? results[i] : 11'h7ff, e[i]); end
        end
        checks++;
        if (match_count !== 7'd2 || last_result !== 11'd0) begin failures++; $display("FAIL gx_match got %0d/%0d want 2/0", match_count, last_result); end
    endtask

    task automatic test_modes;
        int cyc;
        kind = 1;
        run(2'd1, 0, 0, 3, 100, 0, cyc);
        checks++;
        if (results.size() != 3 || (results[0] | results[1] | results[2]) !== 11'd0 || match_count !== 7'd0) begin failures++; $display("FAIL gy_flat got %0d want 0", match_count); end
        run(2'd2, 0, 0, 3, 800, 0, cyc);
        checks++;
        if (match_count !== 7'd0) begin failures++; $display("FAIL strict_gt got %0d want 0", match_count); end
        checks++;
        if (results.size() < 1 || results[0] !== 11'd800) begin failures++; $display("FAIL sum_mode2 got %0d want 800", results.size() > 0 ? results[0] : 11'h7ff); end
        run(2'd3, 0, 0, 3, 799, 0, cyc);
        checks++;
        if (match_count !== 7'd2) begin failures++; $display("FAIL sum_mode3 got %0d want 2", match_count); end
    endtask

    task automatic test_gy_and_offsets;
        int cyc;
        kind = 2;
        run(2'd1, 0, 0, 2, 399, 0, cyc);
        checks++;
        if (results.size() != 2 || results[0] !== 11'd400 || results[1] !== 11'd400 || match_count !== 7'd2) begin failures++; $display("FAIL gy_step got %0d want 2", match_count); end
        run(2'd0, 0, 0, 1, 0, 0, cyc);
        checks++;
        if (last_result !== 11'd0) begin failures++; $display("FAIL gx_on_rows got %0d want 0", last_result); end
        run(2'd1, 1, 0, 1, 0, 0, cyc);
        checks++;
        if (last_result !== 11'd0) begin failures++; $display("FAIL row_offset got %0d want 0", last_result); end
        kind = 3;
        run(2'd0, 0, 0, 1, 0, 0, cyc);
        checks++;
        if (last_result !== 11'd800 || match_count !== 7'd1) begin failures++; $display("FAIL abs_neg got %0d want 800", last_result); end
        kind = 1;
        run(2'd0, 0, 1, 2, 0, 0, cyc);
        checks++;
        if (results.size() != 2 || results[0] !== 11'd800 || results[1] !== 11'd0) begin failures++; $display("FAIL col_offset got %0d want 0", last_result); end
    endtask

    task automatic test_zero;
        int cyc;
        run(2'd0, 0, 0, 0, 0, 0, cyc);
        checks++;
        if (cyc != 1) begin failures++; $display("FAIL zero_latency got %0d want 1", cyc); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (gnt_num != 0 || sram_req !== 1'b0 || done !== 1'b1 || match_count !== 7'd0) begin failures++; $display("FAIL zero_noreq got %0d want 0", gnt_num); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        kind = 1;
        run(2'd0, 0, 0, 3, 100, 5, cyc);
        checks++;
        if (cyc != 34 || match_count !== 7'd2) begin failures++; $display("FAIL start_ignored got %0d want 34", cyc); end
        checks++;
        if (results.size() != 3 || results[0] !== 11'd800 || results[1] !== 11'd800 || results[2] !== 11'd0) begin failures++; $display("FAIL start_ignored_results got %0d want 3", results.size()); end
    endtask

    task automatic test_stall;
        int cyc;
        kind = 1; gnt_wait = 5;
        run(2'd0, 2, 0, 3, 100, 0, cyc);
        gnt_wait = 0;
        checks++;
        if (addr_err != 0) begin failures++; $display("FAIL stall_stable got %0d want 0", addr_err); end
        checks++;
        if (first_addr !== 32'h1000_0080) begin failures++; $display("FAIL first_addr got %h want 10000080", first_addr); end
        checks++;
        if (results.size() != 3 || results[0] !== 11'd800 || results[1] !== 11'd800 || results[2] !== 11'd0 || match_count !== 7'd2) begin failures++; $display("FAIL stall_results got %0d want 2", match_count); end
    endtask

    task automatic test_reset_mid;
        int cyc, n;
        kind = 3;
        run(2'd0, 0, 0, 1, 0, 0, cyc);
        kind = 1; rv_extra = 3; gnt_num = 0; rv_num = 0;
        @(negedge clk);
        mode = 0; row = 0; col = 0; num_patches = 7'd3; threshold = 11'd100; start = 1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            start = 0;
            n++;
        end while (!(gnt_num == 5 && !sram_req && busy) && n < 300);
        checks++;
        if (n >= 300) begin failures++; $display("FAIL mid_wait got %0d want 5", gnt_num); end
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        checks++;
        if ({busy, done, sram_req} !== 3'b000 || sram_addr !== 32'h0 || last_result !== 11'd0 || match_count !== 7'd0) begin failures++; $display("FAIL mid_reset got %b/%0d want 000/0", {busy, done, sram_req}, last_result); end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sram_req !== 1'b0 || last_result !== 11'd0) begin failures++; $display("FAIL late_rvalid got %b want 000", {busy, done, sram_req}); end
        rv_extra = 0;
        run(2'd0, 0, 0, 3, 100, 0, cyc);
        checks++;
        if (cyc != 34 || match_count !== 7'd2 || results.size() != 3 || results[0] !== 11'd800) begin failures++; $display("FAIL after_reset got %0d want 2", match_count); end
    endtask

    initial begin
        test_reset;
        test_uniform;
        test_step_gx;
        test_modes;
        test_gy_and_offsets;
        test_zero;
        test_back_to_back;
        test_stall;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
